core_ma_lsu_merge_read_data: RTL and testbench

Load-response stage directly downstream of the LSU command generator in the MA stage. It collects the one or two aligned 32-bit read beats returned on avl_m0 for a load, and merges them for misaligned accesses. It then shifts, masks and sign/zero-extends the result to the RISC-V load width and holds it for the pipeline until acknowledged. It also flags protocol anomalies: unexpected beats and illegal lengths.

---
 rtl/core_ma_lsu_merge_read_data.sv | 103 ++++++++++
 tb/tb_core_ma_lsu_merge_read_data.sv | 181 ++++++++++++++++++
 2 files changed

// File: rtl/core_ma_lsu_merge_read_data.sv
// Load-response merge: collects one or two aligned read beats, realigns misaligned loads,
// extends to the RISC-V load width and holds the result until the pipeline acknowledges it.
module core_ma_lsu_merge_read_data #(
    parameter bit ERR_STICKY = 1'b0
) (
    input  logic        clk,
    input  logic        rest,
    input  logic [31:0] mem_addr,
    input  logic        mem_read,
    input  logic [2:0]  mem_op_type,
    input  logic [2:0]  mem_op_data_len,
    input  logic [31:0] avl_m0_read_data,
    input  logic        avl_m0_read_data_valid,
    input  logic        load_ack,
    output logic [31:0] load_data,
    output logic        load_data_valid,
    output logic        load_busy,
    output logic        load_err
);

    typedef enum logic [1:0] {IDLE, WAIT_W0, WAIT_W1, DONE} state_t;

    state_t      state, state_nxt;
    logic [1:0]  off_q;
    logic [2:0]  len_q;
    logic        uns_q, two_q;
    logic [31:0] w0_q;

    logic        start, orphan, err_ev, len_ok, two_nxt;
    logic [2:0]  len_eff;
    logic [31:0] mw0, mw1, sh, merged;
    logic [63:0] cat;

    // Only the byte offset and the unsigned bit of funct3 matter here.
    logic unused_bits;
    assign unused_bits = ^{mem_addr[31:2], mem_op_type[1:0]};

    assign start   = (state == IDLE) && mem_read;
    assign orphan  = avl_m0_read_data_valid && ((state == IDLE) || (state == DONE));
    assign len_ok  = (mem_op_data_len == 3'd1) || (mem_op_data_len == 3'd2) ||
                     (mem_op_data_len == 3'd4);
    assign len_eff = len_ok ? mem_op_data_len : 3'd4;
    assign err_ev  = (start && !len_ok) || orphan;
    assign two_nxt = ({1'b0, mem_addr[1:0]} + len_eff) > 3'd4;

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (start) state_nxt = WAIT_W0;
            WAIT_W0: if (avl_m0_read_data_valid) state_nxt = two_q ? WAIT_W1 : DONE;
            WAIT_W1: if (avl_m0_read_data_valid) state_nxt = DONE;
            DONE:    if (load_ack) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // The final beat is merged straight off the bus so the result registers on that edge.
    always_comb begin
        mw0 = (state == WAIT_W0) ? avl_m0_read_data : w0_q;
        mw1 = (state == WAIT_W1) ? avl_m0_read_data : 32'd0;
        cat = {mw1, mw0};
        sh  = 32'(cat >> {off_q, 3'b000});
        case (len_q)
            3'd1:    merged = uns_q ? {24'd0, sh[7:0]}  : {{24{sh[7]}}, sh[7:0]};
            3'd2:    merged = uns_q ? {16'd0, sh[15:0]} : {{16{sh[15]}}, sh[15:0]};
            default: merged = sh;
        endcase
    end

    always_ff @(posedge clk or negedge rest) begin
        if (!rest) begin
            state           <= IDLE;
            off_q           <= 2'd0;
            len_q           <= 3'd0;
            uns_q           <= 1'b0;
            two_q           <= 1'b0;
            w0_q            <= 32'd0;
            load_data       <= 32'd0;
            load_data_valid <= 1'b0;
            load_busy       <= 1'b0;
            load_err        <= 1'b0;
        end else begin
            state     <= state_nxt;
            load_busy <= (state_nxt != IDLE);
            load_err  <= ERR_STICKY ? (load_err | err_ev) : err_ev;
            if (start) begin
                off_q <= mem_addr[1:0];
                len_q <= len_eff;
                uns_q <= mem_op_type[2];
                two_q <= two_nxt;
            end
            if ((state == WAIT_W0) && avl_m0_read_data_valid)
                w0_q <= avl_m0_read_data;
            if ((state != DONE) && (state_nxt == DONE)) begin
                load_data       <= merged;
                load_data_valid <= 1'b1;
            end else if ((state == DONE) && load_ack) begin
                load_data_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_core_ma_lsu_merge_read_data.sv
// Directed bench: expected results queued at issue, popped by a monitor on each new valid result.
module tb_core_ma_lsu_merge_read_data;

    logic        clk = 1'b0;
    logic        rest;
    logic [31:0] mem_addr;
    logic        mem_read;
    logic [2:0]  mem_op_type, mem_op_data_len;
    logic [31:0] rd_data;
    logic        rd_valid, load_ack;
    logic [31:0] ld0, ld1;
    logic        ldv0, ldv1, busy0, busy1, err0, err1;

    int          n_tests = 0;
    int          n_fail  = 0;
    logic [31:0] exp_q[$];
    logic        ldv_prev = 1'b0;

    always #5 clk = ~clk;

    core_ma_lsu_merge_read_data #(.ERR_STICKY(1'b0)) u_dut0 (
        .clk(clk), .rest(rest), .mem_addr(mem_addr), .mem_read(mem_read),
        .mem_op_type(mem_op_type), .mem_op_data_len(mem_op_data_len),
        .avl_m0_read_data(rd_data), .avl_m0_read_data_valid(rd_valid), .load_ack(load_ack),
        .load_data(ld0), .load_data_valid(ldv0), .load_busy(busy0), .load_err(err0));

    core_ma_lsu_merge_read_data #(.ERR_STICKY(1'b1)) u_dut1 (
        .clk(clk), .rest(rest), .mem_addr(mem_addr), .mem_read(mem_read),
        .mem_op_type(mem_op_type), .mem_op_data_len(mem_op_data_len),
        .avl_m0_read_data(rd_data), .avl_m0_read_data_valid(rd_valid), .load_ack(load_ack),
        .load_data(ld1), .load_data_valid(ldv1), .load_busy(busy1), .load_err(err1));

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Monitor: every rising load_data_valid consumes one scoreboard entry.
    always @(negedge clk) begin
        if (ldv0 && !ldv_prev) begin
            if (exp_q.size() == 0) begin
                n_tests++;
                n_fail++;
                $display("FAIL unexpected_result: got %h expected none", ld0);
            end else begin
                chk("load_data", ld0, exp_q.pop_front());
            end
        end
        ldv_prev = ldv0;
    end

    task automatic start_op(input logic [31:0] addr, input logic [2:0] typ, input logic [2:0] len);
        mem_addr = addr; mem_op_type = typ; mem_op_data_len = len; mem_read = 1'b1;
        tick();
        mem_read = 1'b0;
        chk("busy_after_start", {31'd0, busy0}, 32'd1);
    endtask

    task automatic beat(input logic [31:0] d);
        rd_data = d; rd_valid = 1'b1;
        tick();
        rd_valid = 1'b0; rd_data = 32'h0;
    endtask

    task automatic do_load(input logic [31:0] addr, input logic [2:0] typ, input logic [2:0] len,
                           input bit two, input logic [31:0] w0, input logic [31:0] w1,
                           input int gap, input bit orphan_done, input logic [31:0] exp);
        exp_q.push_back(exp);
        start_op(addr, typ, len);
        beat(w0);
        if (two) begin
            chk("wait_w1_no_valid", {31'd0, ldv0}, 32'd0);
            load_ack = 1'b1;            // ack while waiting must be ignored
            for (int i = 0; i < gap; i++) tick();
            load_ack = 1'b0;
            chk("busy_in_wait", {31'd0, busy0}, 32'd1);
            beat(w1);
        end
        chk("valid_latency", {31'd0, ldv0}, 32'd1);
        tick(); tick();
        chk("valid_held", {31'd0, ldv0}, 32'd1);
        chk("data_held", ld0, exp);
        if (orphan_done) begin
            beat(32'hDEADBEEF);
            chk("orphan_done_err", {31'd0, err0}, 32'd1);
            chk("orphan_done_data", ld0, exp);
            chk("orphan_done_valid", {31'd0, ldv0}, 32'd1);
        end
        load_ack = 1'b1;
        tick();
        load_ack = 1'b0;
        chk("valid_after_ack", {31'd0, ldv0}, 32'd0);
        chk("busy_after_ack", {31'd0, busy0}, 32'd0);
        chk("data_kept", ld0, exp);
        tick();
    endtask

    task automatic pulse_reset();
        rest = 1'b0;
        tick();
        rest = 1'b1;
        tick();
    endtask

    initial begin
        rest = 1'b0; mem_addr = 32'h0; mem_read = 1'b0; mem_op_type = 3'd0;
        mem_op_data_len = 3'd0; rd_data = 32'h0; rd_valid = 1'b0; load_ack = 1'b0;
        tick(); tick();
        chk("rst_data", ld0, 32'h0);
        chk("rst_valid", {31'd0, ldv0}, 32'd0);
        chk("rst_busy", {31'd0, busy0}, 32'd0);
        chk("rst_err0", {31'd0, err0}, 32'd0);
        chk("rst_err1", {31'd0, err1}, 32'd0);
        rest = 1'b1;
        tick();

        //       addr          typ   len  two  w0            w1            gap orph expected
        do_load(32'h100, 3'b010, 3'd4, 0, 32'h89ABCDEF, 32'h0,        0, 0, 32'h89ABCDEF);
        do_load(32'h103, 3'b000, 3'd1, 0, 32'h80123456, 32'h0,        0, 1, 32'hFFFFFF80);
        do_load(32'h103, 3'b100, 3'd1, 0, 32'h80123456, 32'h0,        0, 0, 32'h00000080);
        do_load(32'h103, 3'b001, 3'd2, 1, 32'hAA112233, 32'h445566BB, 0, 0, 32'hFFFFBBAA);
        do_load(32'h103, 3'b101, 3'd2, 1, 32'hAA112233, 32'h445566BB, 0, 0, 32'h0000BBAA);
        do_load(32'h102, 3'b010, 3'd4, 1, 32'h1234CCCC, 32'hDDDD5678, 3, 0, 32'h56781234);
        do_load(32'h101, 3'b001, 3'd2, 0, 32'h00FF7F00, 32'h0,        0, 0, 32'hFFFFFF7F);
        do_load(32'h102, 3'b101, 3'd2, 0, 32'h80010000, 32'h0,        0, 0, 32'h00008001);

        // Orphan beat in IDLE: pulse vs sticky error
        pulse_reset();
        chk("sticky_cleared", {31'd0, err1}, 32'd0);
        beat(32'h12345678);
        chk("orphan_err0", {31'd0, err0}, 32'd1);
        chk("orphan_err1", {31'd0, err1}, 32'd1);
        chk("orphan_busy", {31'd0, busy0}, 32'd0);
        tick();
        chk("orphan_err0_pulse", {31'd0, err0}, 32'd0);
        chk("orphan_err1_sticky", {31'd0, err1}, 32'd1);

        // Illegal length 3 behaves as a word load and flags an error
        pulse_reset();
        exp_q.push_back(32'h11223344);
        start_op(32'h100, 3'b010, 3'd3);
        chk("badlen_err0", {31'd0, err0}, 32'd1);
        chk("badlen_err1", {31'd0, err1}, 32'd1);
        beat(32'h11223344);
        chk("badlen_err0_pulse", {31'd0, err0}, 32'd0);
        chk("badlen_err1_sticky", {31'd0, err1}, 32'd1);
        chk("badlen_valid", {31'd0, ldv0}, 32'd1);
        load_ack = 1'b1;
        tick();
        load_ack = 1'b0;
        tick();

        // Asynchronous reset while in WAIT_W1
        start_op(32'h102, 3'b010, 3'd4);
        beat(32'hFFFFFFFF);
        #2 rest = 1'b0;
        #1;
        chk("midrst_data", ld0, 32'h0);
        chk("midrst_valid", {31'd0, ldv0}, 32'd0);
        chk("midrst_busy", {31'd0, busy0}, 32'd0);
        chk("midrst_err1", {31'd0, err1}, 32'd0);
        tick();
        rest = 1'b1;
        tick();
        do_load(32'h100, 3'b010, 3'd4, 0, 32'h00000007, 32'h0, 0, 0, 32'h00000007);

        tick(); tick();
        chk("scoreboard_drained", 32'(exp_q.size()), 32'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
